// File: rtl/ram_sp_responder_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ram_sp_responder_if : controller <-> RAM responder address/data bus
// Rev 1.0
// ---------------------------------------------------------------------------
interface ram_sp_responder_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              wren;
  logic              rden;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] q;
  logic              rd_valid;
  logic              init_done;

  modport master (
    output wren, rden, addr, data_in,
    input  q, rd_valid, init_done
  );

  modport slave (
    input  wren, rden, addr, data_in,
    output q, rd_valid, init_done
  );
endinterface
`default_nettype wire

// File: rtl/ram_sp_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ram_sp_responder : single-port RAM, 1-cycle registered read, ramp self-init
// Rev 1.0
// ---------------------------------------------------------------------------
module ram_sp_responder #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 256,
  parameter int INIT_STEP = 1
) (
  input  logic                sys_clk,
  input  logic                rst_n,
  ram_sp_responder_if.slave   bus
);

  typedef enum logic [0:0] {
    S_INIT  = 1'b0,
    S_READY = 1'b1
  } state_t;

  localparam logic [ADDR_W:0]   C_LAST = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [DATA_W-1:0] C_STEP = DATA_W'(INIT_STEP);

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [ADDR_W:0]   init_ptr_q, init_ptr_d;
  logic [DATA_W-1:0] q_q, q_d;
  logic              rd_valid_q, rd_valid_d;
  logic              init_done_q, init_done_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              addr_ok;

  assign addr_ok = (32'(bus.addr) < 32'(DEPTH));

  always_comb begin
    state_d     = state_q;
    init_ptr_d  = init_ptr_q;
    q_d         = q_q;
    rd_valid_d  = 1'b0;
    init_done_d = init_done_q;
    mem_we      = 1'b0;
    mem_waddr   = bus.addr;
    mem_wdata   = bus.data_in;
    case (state_q)
      S_INIT: begin
        // Truncating both factors first keeps the low DATA_W bits exact.
        mem_we     = 1'b1;
        mem_waddr  = init_ptr_q[ADDR_W-1:0];
        mem_wdata  = DATA_W'(init_ptr_q) * C_STEP;
        init_ptr_d = init_ptr_q + 1'b1;
        q_d        = '0;
        if (init_ptr_q == C_LAST) begin
          state_d     = S_READY;
          init_done_d = 1'b1;
        end
      end
      S_READY: begin
        if (bus.wren) begin
          mem_we = addr_ok;
          if (bus.rden) begin
            q_d        = bus.data_in;
            rd_valid_d = 1'b1;
          end
        end else if (bus.rden) begin
          q_d        = addr_ok ? mem[bus.addr] : '0;
          rd_valid_d = 1'b1;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_INIT;
      init_ptr_q  <= '0;
      q_q         <= '0;
      rd_valid_q  <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_ptr_q  <= init_ptr_d;
      q_q         <= q_d;
      rd_valid_q  <= rd_valid_d;
      init_done_q <= init_done_d;
    end
  end

  // Storage has no reset; contents come only from the sweep and later writes.
  always_ff @(posedge sys_clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign bus.q         = q_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.init_done = init_done_q;

endmodule
`default_nettype wire
